// File: rtl/mmio_button_input.sv
// Pushbutton front end for the MMIO input port: synchronize, debounce, and latch press events.
// Optional release pulse/flags are built when MMIO_BUTTON_RELEASE_EVENT_EN is defined.
module mmio_button_input #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                   clock,
  input  logic                   notReset,
  input  logic [NUM_BUTTONS-1:0] rawButton,
  input  logic                   clearPress,
  input  logic [NUM_BUTTONS-1:0] clearMask,
  output logic [NUM_BUTTONS-1:0] stableButton,
  output logic [NUM_BUTTONS-1:0] pressPulse,
  output logic [NUM_BUTTONS-1:0] pressEvent,
`ifdef MMIO_BUTTON_RELEASE_EVENT_EN
  output logic [NUM_BUTTONS-1:0] releasePulse,
`endif
  output logic [31:0]            mmioWord
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BUTTONS-1:0] pressed_n;
  logic [NUM_BUTTONS-1:0] sync1;
  logic [NUM_BUTTONS-1:0] sync2;
  logic [NUM_BUTTONS-1:0] diff;
  logic [NUM_BUTTONS-1:0] done;
  logic [NUM_BUTTONS-1:0] clr;
  logic [CW-1:0]          cnt [NUM_BUTTONS];

  // Polarity is folded in ahead of the synchronizer so reset value 0 means "not pressed".
  assign pressed_n = ACTIVE_LOW ? ~rawButton : rawButton;

  // clearPress is a one-cycle strobe with no ready: honoured on every edge it is high.
  assign clr = clearPress ? clearMask : '0;

  always_comb begin
    diff = '0;
    done = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      diff[i] = sync2[i] ^ stableButton[i];
      done[i] = diff[i] && (cnt[i] == LAST);
    end
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      sync1        <= '0;
      sync2        <= '0;
      stableButton <= '0;
      pressPulse   <= '0;
      pressEvent   <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt[i] <= '0;
    end else begin
      sync1        <= pressed_n;
      sync2        <= sync1;
      stableButton <= stableButton ^ done;
      pressPulse   <= done & sync2;
      // Set term is OR'd after the clear so a simultaneous press is never lost.
      pressEvent   <= (pressEvent & ~clr) | (done & sync2);
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (!diff[i] || done[i]) cnt[i] <= '0;
        else                     cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

`ifdef MMIO_BUTTON_RELEASE_EVENT_EN
  logic [NUM_BUTTONS-1:0] releaseEvent;

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      releasePulse <= '0;
      releaseEvent <= '0;
    end else begin
      releasePulse <= done & ~sync2;
      releaseEvent <= (releaseEvent & ~clr) | (done & ~sync2);
    end
  end
`endif

  // Bits [7:4] stay zero so the top level can OR in LED feedback.
  always_comb begin
    mmioWord = '0;
    mmioWord[NUM_BUTTONS-1:0]  = stableButton;
    mmioWord[8 +: NUM_BUTTONS] = pressEvent;
`ifdef MMIO_BUTTON_RELEASE_EVENT_EN
    mmioWord[16 +: NUM_BUTTONS] = releaseEvent;
`endif
  end

endmodule

// File: tb/tb_mmio_button_input.sv
// Directed bench for mmio_button_input with DEBOUNCE_CYCLES=4, active-low, 4 buttons.
// Release-event expectations are included when MMIO_BUTTON_RELEASE_EVENT_EN is defined.
module tb_mmio_button_input;

  localparam int NB = 4;

  logic          clock;
  logic          notReset;
  logic [NB-1:0] rawButton;
  logic          clearPress;
  logic [NB-1:0] clearMask;
  logic [NB-1:0] stableButton;
  logic [NB-1:0] pressPulse;
  logic [NB-1:0] pressEvent;
  logic [31:0]   mmioWord;
`ifdef MMIO_BUTTON_RELEASE_EVENT_EN
  logic [NB-1:0] releasePulse;
  localparam logic [31:0] REL2 = 32'h0004_0000;
`else
  localparam logic [31:0] REL2 = 32'h0;
`endif

  int vectors;
  int miscompares;
  int pcnt [NB];

  mmio_button_input #(
    .NUM_BUTTONS(NB),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock),
    .notReset(notReset),
    .rawButton(rawButton),
    .clearPress(clearPress),
    .clearMask(clearMask),
    .stableButton(stableButton),
    .pressPulse(pressPulse),
    .pressEvent(pressEvent),
`ifdef MMIO_BUTTON_RELEASE_EVENT_EN
    .releasePulse(releasePulse),
`endif
    .mmioWord(mmioWord)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // pulse tally, sampled mid-cycle
  initial for (int i = 0; i < NB; i++) pcnt[i] = 0;
  always @(negedge clock)
    for (int i = 0; i < NB; i++) if (pressPulse[i]) pcnt[i]++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    notReset    = 1'b0;
    rawButton   = 4'hF;
    clearPress  = 1'b0;
    clearMask   = 4'h0;

    // reset with all buttons released
    tick(3);
    check("rst_word", mmioWord, 32'h0);
    check("rst_stable", {28'h0, stableButton}, 32'h0);
    check("rst_pulse", {28'h0, pressPulse}, 32'h0);
    notReset = 1'b1;
    tick(10);
    check("idle_word", mmioWord, 32'h0);

    // press button 0: flips on edge 6
    rawButton = 4'hE;
    tick(5);
    check("b0_edge5_stable", {28'h0, stableButton}, 32'h0);
    tick(1);
    check("b0_edge6_stable", {28'h0, stableButton}, 32'h1);
    check("b0_edge6_pulse", {28'h0, pressPulse}, 32'h1);
    check("b0_word", mmioWord, 32'h0000_0101);
    tick(1);
    check("b0_pulse_one_cycle", {28'h0, pressPulse}, 32'h0);

    // bounce on button 1: low 3, high 1, then low held
    rawButton = 4'hC;
    tick(3);
    rawButton = 4'hE;
    tick(1);
    rawButton = 4'hC;
    tick(5);
    check("b1_bounce_no_flip", {28'h0, stableButton}, 32'h1);
    check("b1_bounce_no_pulse", {28'h0, pressPulse}, 32'h0);
    tick(1);
    check("b1_flip", {28'h0, stableButton}, 32'h3);
    check("b1_pulse", {28'h0, pressPulse}, 32'h2);
    tick(1);
    check("b1_pulse_one_cycle", {28'h0, pressPulse}, 32'h0);
    check("b1_event", {28'h0, pressEvent}, 32'h3);

    // selective clear of bit 0
    clearPress = 1'b1;
    clearMask  = 4'h1;
    tick(1);
    clearPress = 1'b0;
    clearMask  = 4'h0;
    check("clr_b0", {28'h0, pressEvent}, 32'h2);

    // release button 0, re-press with a clear landing on the flip edge
    rawButton = 4'hD;
    tick(6);
    check("b0_release", {28'h0, stableButton}, 32'h2);
    check("b0_release_event_kept", {28'h0, pressEvent}, 32'h2);
    rawButton = 4'hC;
    tick(5);
    clearPress = 1'b1;
    clearMask  = 4'h1;
    tick(1);
    clearPress = 1'b0;
    clearMask  = 4'h0;
    check("setwins_stable", {28'h0, stableButton}, 32'h3);
    check("setwins_event", {28'h0, pressEvent}, 32'h3);

    // clear strobe with empty mask
    clearPress = 1'b1;
    tick(1);
    clearPress = 1'b0;
    check("clr_mask0", {28'h0, pressEvent}, 32'h3);

    // press then release button 2
    rawButton = 4'h8;
    tick(6);
    check("b2_press_stable", {28'h0, stableButton}, 32'h7);
    check("b2_press_pulse", {28'h0, pressPulse}, 32'h4);
    rawButton = 4'hC;
    tick(5);
    check("b2_rel_edge5", {28'h0, stableButton}, 32'h7);
    tick(1);
    check("b2_rel_stable", {28'h0, stableButton}, 32'h3);
    check("b2_rel_no_pulse", {28'h0, pressPulse}, 32'h0);
    check("b2_rel_event", {28'h0, pressEvent}, 32'h7);
    check("b2_rel_word", mmioWord, 32'h0000_0703 | REL2);
`ifdef MMIO_BUTTON_RELEASE_EVENT_EN
    check("b2_rel_pulse", {28'h0, releasePulse}, 32'h4);
    tick(1);
    check("b2_rel_pulse_one_cycle", {28'h0, releasePulse}, 32'h0);
`endif

    // clearing the released button's flag leaves others alone
    clearPress = 1'b1;
    clearMask  = 4'h4;
    tick(1);
    clearPress = 1'b0;
    clearMask  = 4'h0;
    check("clr_b2", mmioWord, 32'h0000_0303);

    // reset mid-debounce on button 3 (counter at 2)
    rawButton = 4'h0;
    tick(4);
    #2;
    notReset = 1'b0;
    #1;
    check("async_rst_word", mmioWord, 32'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    check("held_rst_word", mmioWord, 32'h0);
    notReset = 1'b1;
    tick(5);
    check("post_rst_edge5", {28'h0, stableButton}, 32'h0);
    tick(1);
    check("post_rst_stable", {28'h0, stableButton}, 32'hF);
    check("post_rst_pulse", {28'h0, pressPulse}, 32'hF);
    check("post_rst_word", mmioWord, 32'h0000_0F0F);
    tick(2);

    check("pulses_b0", pcnt[0], 32'd3);
    check("pulses_b1", pcnt[1], 32'd2);
    check("pulses_b2", pcnt[2], 32'd2);
    check("pulses_b3", pcnt[3], 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
